// File: rtl/mem_pkg.sv
// Shared types and elaboration helpers for the beat-serialised line memory.
// Line-derived sizes depend on module parameters, so they are exposed as functions.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_t;

  function automatic int calc_line_w(input int word_w, input int line_words);
    return word_w * line_words;
  endfunction

  function automatic int calc_beats(input int line_words, input int words_per_beat);
    return line_words / words_per_beat;
  endfunction

  // A line must split into a whole number of beats.
  function automatic bit params_legal(input int line_words, input int words_per_beat);
    return (words_per_beat > 0) && (line_words % words_per_beat == 0);
  endfunction

endpackage

// File: rtl/beat_word_ram.sv
// Word-addressed storage with one WORDS_PER_BEAT-wide synchronous port.
// Consecutive words of a beat wrap modulo the array depth.
module beat_word_ram #(
  parameter int WORD_W         = 32,
  parameter int WORDS_PER_BEAT = 1,
  parameter int ADDR_W         = 10
) (
  input  logic                             clk_i,
  input  logic [ADDR_W-1:0]                addr_i,
  input  logic                             rd_en_i,
  input  logic [WORDS_PER_BEAT-1:0]        wr_en_i,
  input  logic [WORD_W*WORDS_PER_BEAT-1:0] wdata_i,
  output logic [WORD_W*WORDS_PER_BEAT-1:0] rdata_o
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [WORD_W-1:0]                mem_q [DEPTH];
  logic [WORD_W*WORDS_PER_BEAT-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    for (int j = 0; j < WORDS_PER_BEAT; j++) begin
      if (wr_en_i[j]) begin
        mem_q[addr_i + ADDR_W'(j)] <= wdata_i[j*WORD_W +: WORD_W];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rd_en_i) begin
      for (int j = 0; j < WORDS_PER_BEAT; j++) begin
        rdata_q[j*WORD_W +: WORD_W] <= mem_q[addr_i + ADDR_W'(j)];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/line_data_memory.sv
// Line memory front end: valid/ready request handshake, beat-serialised
// read/write of a LINE_WORDS line, and a held read response with backpressure.
module line_data_memory
  import mem_pkg::*;
#(
  parameter int WORD_W         = 32,
  parameter int LINE_WORDS     = 4,
  parameter int WORDS_PER_BEAT = 1,
  parameter int ADDR_W         = 10
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_write,
  input  logic [ADDR_W-1:0]            req_addr,
  input  logic [WORD_W*LINE_WORDS-1:0] req_wdata,
  input  logic [LINE_WORDS-1:0]        req_wmask,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [WORD_W*LINE_WORDS-1:0] rsp_rdata
);

  localparam int LINE_W    = calc_line_w(WORD_W, LINE_WORDS);
  localparam int BEATS     = calc_beats(LINE_WORDS, WORDS_PER_BEAT);
  localparam int BEAT_BITS = WORD_W * WORDS_PER_BEAT;
  localparam int BEAT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;

  if (!params_legal(LINE_WORDS, WORDS_PER_BEAT)) begin : g_bad_params
    $error("line_data_memory: WORDS_PER_BEAT must divide LINE_WORDS");
  end

  state_t                    state_q, state_d;
  logic [BEAT_W-1:0]         beat_q, beat_d;
  logic [ADDR_W-1:0]         addr_q, addr_d;
  logic [LINE_W-1:0]         wdata_q, wdata_d;
  logic [LINE_WORDS-1:0]     wmask_q, wmask_d;
  logic [LINE_W-1:0]         rbuf_q, rbuf_d;

  logic                      last_beat;
  logic [BEAT_BITS-1:0]      beat_wdata;
  logic [WORDS_PER_BEAT-1:0] beat_wmask;
  logic [ADDR_W-1:0]         wr_off, rd_off;

  logic [ADDR_W-1:0]         ram_addr;
  logic                      ram_rd_en;
  logic [WORDS_PER_BEAT-1:0] ram_wr_en;
  logic [BEAT_BITS-1:0]      ram_rdata;

  assign last_beat = (beat_q == BEAT_W'(BEATS - 1));

  // The read port runs one beat ahead: beat 0 is fetched on the accept edge so
  // each READ edge can capture the beat that the RAM already holds.
  always_comb begin
    beat_wdata = '0;
    beat_wmask = '0;
    wr_off     = '0;
    rd_off     = '0;
    for (int b = 0; b < BEATS; b++) begin
      if (beat_q == BEAT_W'(b)) begin
        beat_wdata = wdata_q[b*BEAT_BITS +: BEAT_BITS];
        beat_wmask = wmask_q[b*WORDS_PER_BEAT +: WORDS_PER_BEAT];
        wr_off     = ADDR_W'(b * WORDS_PER_BEAT);
        rd_off     = ADDR_W'((b + 1) * WORDS_PER_BEAT);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req_valid) state_d = req_write ? WRITE : READ;
      WRITE:   if (last_beat) state_d = IDLE;
      READ:    if (last_beat) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state_q == IDLE);
    rsp_valid = (state_q == RESP);
    ram_rd_en = ((state_q == IDLE) && req_valid) || (state_q == READ);
    ram_wr_en = ((state_q == WRITE) && rst_n) ? beat_wmask : '0;
    unique case (state_q)
      IDLE:    ram_addr = req_addr;
      WRITE:   ram_addr = addr_q + wr_off;
      default: ram_addr = addr_q + rd_off;
    endcase
  end

  always_comb begin
    beat_d  = beat_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    rbuf_d  = rbuf_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          wmask_d = req_wmask;
          beat_d  = '0;
        end
      end
      READ: begin
        for (int b = 0; b < BEATS; b++) begin
          if (beat_q == BEAT_W'(b)) rbuf_d[b*BEAT_BITS +: BEAT_BITS] = ram_rdata;
        end
        beat_d = last_beat ? '0 : beat_q + BEAT_W'(1);
      end
      WRITE:   beat_d = last_beat ? '0 : beat_q + BEAT_W'(1);
      default: beat_d = beat_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      beat_q <= '0;
      rbuf_q <= '0;
    end else begin
      beat_q <= beat_d;
      rbuf_q <= rbuf_d;
    end
  end

  // Request latches need no reset; they are only consumed after an accept.
  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    wmask_q <= wmask_d;
  end

  assign rsp_rdata = rbuf_q;

  beat_word_ram #(
    .WORD_W        (WORD_W),
    .WORDS_PER_BEAT(WORDS_PER_BEAT),
    .ADDR_W        (ADDR_W)
  ) u_ram (
    .clk_i  (clk),
    .addr_i (ram_addr),
    .rd_en_i(ram_rd_en),
    .wr_en_i(ram_wr_en),
    .wdata_i(beat_wdata),
    .rdata_o(ram_rdata)
  );

endmodule

// File: tb/tb_line_data_memory.sv
// Bench for line_data_memory: scripted scenarios plus random traffic checked
// against a word-array model; a second instance covers the two-word-beat build.
module tb_line_data_memory;

  localparam int WORD_W     = 32;
  localparam int LINE_WORDS = 4;
  localparam int ADDR_W     = 10;
  localparam int DEPTH      = 1024;
  localparam int LINE_W     = 128;
  localparam int BEATS      = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              reqValid, reqReady, reqWrite;
  logic [ADDR_W-1:0] reqAddr;
  logic [LINE_W-1:0] reqWdata;
  logic [3:0]        reqWmask;
  logic              rspValid, rspReady;
  logic [LINE_W-1:0] rspRdata;

  logic              b2ReqValid, b2ReqReady, b2ReqWrite;
  logic [ADDR_W-1:0] b2ReqAddr;
  logic [LINE_W-1:0] b2ReqWdata;
  logic [3:0]        b2ReqWmask;
  logic              b2RspValid, b2RspReady;
  logic [LINE_W-1:0] b2RspRdata;

  int checks = 0;
  int errors = 0;

  logic [WORD_W-1:0] refMem [DEPTH];
  bit                known  [DEPTH];

  localparam logic [LINE_W-1:0] S1_LINE = 128'hDDDD0003_CCCC0002_BBBB0001_AAAA0000;

  always #5 clk = ~clk;

  line_data_memory #(.WORD_W(32), .LINE_WORDS(4), .WORDS_PER_BEAT(1), .ADDR_W(10)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(reqValid), .req_ready(reqReady), .req_write(reqWrite),
    .req_addr(reqAddr), .req_wdata(reqWdata), .req_wmask(reqWmask),
    .rsp_valid(rspValid), .rsp_ready(rspReady), .rsp_rdata(rspRdata)
  );

  line_data_memory #(.WORD_W(32), .LINE_WORDS(4), .WORDS_PER_BEAT(2), .ADDR_W(10)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(b2ReqValid), .req_ready(b2ReqReady), .req_write(b2ReqWrite),
    .req_addr(b2ReqAddr), .req_wdata(b2ReqWdata), .req_wmask(b2ReqWmask),
    .rsp_valid(b2RspValid), .rsp_ready(b2RspReady), .rsp_rdata(b2RspRdata)
  );

  // Count every comparison and report any mismatch.
  task automatic checkOutput(input string tag, input logic [LINE_W-1:0] got,
                             input logic [LINE_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int wordAddr(input logic [ADDR_W-1:0] a, input int i);
    return (int'(a) + i) % DEPTH;
  endfunction

  function automatic logic [LINE_W-1:0] expLine(input logic [ADDR_W-1:0] a);
    logic [LINE_W-1:0] l;
    l = '0;
    for (int i = 0; i < LINE_WORDS; i++) l[i*WORD_W +: WORD_W] = refMem[wordAddr(a, i)];
    return l;
  endfunction

  function automatic logic [LINE_W-1:0] knownMask(input logic [ADDR_W-1:0] a);
    logic [LINE_W-1:0] m;
    m = '0;
    for (int i = 0; i < LINE_WORDS; i++) if (known[wordAddr(a, i)]) m[i*WORD_W +: WORD_W] = '1;
    return m;
  endfunction

  task automatic modelWrite(input logic [ADDR_W-1:0] a, input logic [LINE_W-1:0] d,
                            input logic [3:0] m);
    for (int i = 0; i < LINE_WORDS; i++) begin
      if (m[i]) begin
        refMem[wordAddr(a, i)] = d[i*WORD_W +: WORD_W];
        known[wordAddr(a, i)]  = 1'b1;
      end
    end
  endtask

  task automatic waitReady();
    int n = 0;
    while (!reqReady && n < 20) begin
      tick();
      n++;
    end
    if (!reqReady) checkOutput("req_ready_timeout", {127'd0, reqReady}, 128'd1);
  endtask

  // One full request: accept, timing of busy/valid, data, optional backpressure.
  task automatic applyStimulus(input bit wr, input logic [ADDR_W-1:0] a,
                               input logic [LINE_W-1:0] d, input logic [3:0] m,
                               input int hold);
    logic [LINE_W-1:0] exp, km;
    waitReady();
    reqValid = 1'b1; reqWrite = wr; reqAddr = a; reqWdata = d; reqWmask = m;
    exp = expLine(a);
    km  = knownMask(a);
    tick();
    reqValid = 1'b0; reqWrite = 1'($urandom); reqAddr = ADDR_W'($urandom);
    reqWdata = {$urandom, $urandom, $urandom, $urandom}; reqWmask = 4'($urandom);
    if (wr) begin
      modelWrite(a, d, m);
      for (int k = 0; k < BEATS; k++) begin
        checkOutput("wr_busy", {127'd0, reqReady}, 128'd0);
        tick();
      end
      checkOutput("wr_done_ready", {127'd0, reqReady}, 128'd1);
    end else begin
      for (int k = 0; k < BEATS; k++) begin
        checkOutput("rd_pending", {127'd0, rspValid}, 128'd0);
        tick();
      end
      checkOutput("rd_valid", {127'd0, rspValid}, 128'd1);
      checkOutput("rd_data", rspRdata & km, exp & km);
      for (int k = 0; k < hold; k++) begin
        tick();
        checkOutput("hold_valid", {127'd0, rspValid}, 128'd1);
        checkOutput("hold_data", rspRdata & km, exp & km);
        checkOutput("hold_busy", {127'd0, reqReady}, 128'd0);
      end
      rspReady = 1'b1;
      tick();
      rspReady = 1'b0;
      checkOutput("rsp_done_valid", {127'd0, rspValid}, 128'd0);
      checkOutput("rsp_done_ready", {127'd0, reqReady}, 128'd1);
      checkOutput("rsp_keep_data", rspRdata & km, exp & km);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [LINE_W-1:0] d;
    logic [ADDR_W-1:0] a;
    rst_n = 1'b0; reqValid = 1'b0; reqWrite = 1'b0; reqAddr = '0; reqWdata = '0;
    reqWmask = '0; rspReady = 1'b0;
    b2ReqValid = 1'b0; b2ReqWrite = 1'b0; b2ReqAddr = '0; b2ReqWdata = '0;
    b2ReqWmask = '0; b2RspReady = 1'b1;
    for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    checkOutput("reset_req_ready", {127'd0, reqReady}, 128'd1);
    checkOutput("reset_rsp_valid", {127'd0, rspValid}, 128'd0);
    checkOutput("reset_rsp_rdata", rspRdata, 128'd0);

    // Two-word-beat build: 2-cycle write occupancy and 2-cycle read latency.
    b2ReqValid = 1'b1; b2ReqWrite = 1'b1; b2ReqAddr = 10'h010;
    b2ReqWdata = S1_LINE; b2ReqWmask = 4'hF;
    tick();
    b2ReqValid = 1'b0; b2ReqWdata = '0;
    checkOutput("b2_wr_busy0", {127'd0, b2ReqReady}, 128'd0);
    tick();
    checkOutput("b2_wr_busy1", {127'd0, b2ReqReady}, 128'd0);
    tick();
    checkOutput("b2_wr_done", {127'd0, b2ReqReady}, 128'd1);
    b2ReqValid = 1'b1; b2ReqWrite = 1'b0;
    tick();
    b2ReqValid = 1'b0;
    checkOutput("b2_rd_pending0", {127'd0, b2RspValid}, 128'd0);
    tick();
    checkOutput("b2_rd_pending1", {127'd0, b2RspValid}, 128'd0);
    tick();
    checkOutput("b2_rd_valid", {127'd0, b2RspValid}, 128'd1);
    checkOutput("b2_rd_data", b2RspRdata, S1_LINE);
    tick();
    checkOutput("b2_rsp_done", {127'd0, b2RspValid}, 128'd0);

    // Full line write then read back.
    applyStimulus(1'b1, 10'h010, S1_LINE, 4'hF, 0);
    applyStimulus(1'b0, 10'h010, '0, 4'h0, 0);
    checkOutput("s1_literal", rspRdata, S1_LINE);

    // Masked write leaves words 1 and 3 untouched.
    applyStimulus(1'b1, 10'h010, {4{32'h11111111}}, 4'b0101, 0);
    applyStimulus(1'b0, 10'h010, '0, 4'h0, 0);
    checkOutput("mask_literal", rspRdata, 128'hDDDD0003_11111111_BBBB0001_11111111);

    // Address wrap at the top of the array.
    applyStimulus(1'b1, 10'h3FE, {32'd4, 32'd3, 32'd2, 32'd1}, 4'hF, 0);
    applyStimulus(1'b0, 10'h3FE, '0, 4'h0, 0);
    checkOutput("wrap_literal", rspRdata, {32'd4, 32'd3, 32'd2, 32'd1});
    applyStimulus(1'b0, 10'h000, '0, 4'h0, 0);
    checkOutput("wrap_low_words", rspRdata[63:0], {32'd4, 32'd3});

    // Backpressure: response held for five cycles.
    applyStimulus(1'b0, 10'h010, '0, 4'h0, 5);

    // Reset during beat 2 of a write: only beats 0 and 1 reach memory.
    waitReady();
    d = 128'h55550003_55550002_55550001_55550000;
    reqValid = 1'b1; reqWrite = 1'b1; reqAddr = 10'h010; reqWdata = d; reqWmask = 4'hF;
    tick();
    reqValid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    modelWrite(10'h010, d, 4'b0011);
    checkOutput("midrst_req_ready", {127'd0, reqReady}, 128'd1);
    checkOutput("midrst_rsp_valid", {127'd0, rspValid}, 128'd0);
    checkOutput("midrst_rsp_rdata", rspRdata, 128'd0);
    applyStimulus(1'b0, 10'h010, '0, 4'h0, 0);
    checkOutput("midrst_literal", rspRdata, 128'hDDDD0003_11111111_55550001_55550000);

    // Random traffic over a window straddling the wrap point.
    for (int n = 0; n < 40; n++) begin
      a = ADDR_W'(($urandom_range(0, 39) + 1000) % DEPTH);
      d = {$urandom, $urandom, $urandom, $urandom};
      applyStimulus(1'($urandom_range(0, 1)), a, d, 4'($urandom), $urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
